// File: rtl/data_ram.sv
// data_ram: word-organised scratch RAM with byte/half/word access, alignment and
// range checking, and a fixed, parameterised access latency.
`default_nettype none

module data_ram #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_ready,
  output logic                  o_ack,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_err
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;
  localparam logic [3:0] c_LAST_WAIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam int         c_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]            r_state, w_next;
  logic [3:0]            r_cnt;
  logic                  r_we, r_uns, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_size;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;

  // In IDLE the live inputs are used so a zero-wait access can commit on its accept edge.
  logic                  w_we, w_uns, w_err, w_enter_resp, w_commit;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-3:0] w_idx;
  logic [1:0]            w_size, w_lane;
  logic [DATA_WIDTH-1:0] w_wdata, w_wlanes, w_word, w_shift, w_load;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_mem [DEPTH];

  assign w_we    = (r_state == c_IDLE) ? i_we       : r_we;
  assign w_uns   = (r_state == c_IDLE) ? i_unsigned : r_uns;
  assign w_addr  = (r_state == c_IDLE) ? i_addr     : r_addr;
  assign w_size  = (r_state == c_IDLE) ? i_size     : r_size;
  assign w_wdata = (r_state == c_IDLE) ? i_wdata    : r_wdata;
  assign w_idx   = w_addr[ADDR_WIDTH-1:2];
  assign w_lane  = w_addr[1:0];

  assign w_err = (w_size == 2'b11)
              || (w_size == 2'b01 && w_lane[0])
              || (w_size == 2'b10 && w_lane != 2'b00)
              || (w_idx >= (ADDR_WIDTH-2)'(DEPTH));

  assign w_enter_resp = !i_rst && (w_next == c_RESP);
  assign w_commit     = w_enter_resp && w_we && !w_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == c_WAIT) ? r_cnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (i_req) w_next = (WAIT_STATES == 0) ? c_RESP : c_WAIT;
      c_WAIT:  if (r_cnt == c_LAST_WAIT) w_next = c_RESP;
      c_RESP:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (r_state == c_IDLE);
    o_ack   = (r_state == c_RESP);
    o_err   = r_err;
    o_rdata = r_rdata;
  end

  always_ff @(posedge i_clk) begin
    if (r_state == c_IDLE && i_req) begin
      r_we    <= i_we;
      r_uns   <= i_unsigned;
      r_addr  <= i_addr;
      r_size  <= i_size;
      r_wdata <= i_wdata;
    end
  end

  always_comb begin
    w_be = 4'b0000;
    case (w_size)
      2'b00: w_be[w_lane] = 1'b1;
      2'b01: begin
        w_be[w_lane]        = 1'b1;
        w_be[w_lane + 2'd1] = 1'b1;
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_wlanes = w_wdata << {w_lane, 3'b000};

  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    logic [DATA_WIDTH-1:0] r_word = DATA_WIDTH'(k + 1);
    assign w_mem[k] = r_word;
    always_ff @(posedge i_clk) begin
      if (w_commit && w_idx == (ADDR_WIDTH-2)'(k)) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) r_word[8*b +: 8] <= w_wlanes[8*b +: 8];
        end
      end
    end
  end

  assign w_word  = w_mem[w_idx[c_IW-1:0]];
  assign w_shift = w_word >> {w_lane, 3'b000};

  always_comb begin
    case (w_size)
      2'b00:   w_load = w_uns ? {{(DATA_WIDTH-8){1'b0}}, w_shift[7:0]}
                              : {{(DATA_WIDTH-8){w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_load = w_uns ? {{(DATA_WIDTH-16){1'b0}}, w_shift[15:0]}
                              : {{(DATA_WIDTH-16){w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_word;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || !w_enter_resp) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err   <= w_err;
      r_rdata <= (w_err || w_we) ? '0 : w_load;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_ram.sv
// tb_data_ram: three data_ram instances (WAIT_STATES 1, 3, 0) checked against a byte-array model.
`default_nettype none

module tb_data_ram;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic [2:0]  req = 3'b000;
  logic        we = 1'b0, uns = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0]  size = 2'b00;
  logic        rdy [3];
  logic        ack [3];
  logic        err [3];
  logic [31:0] rdata [3];

  int WS [3] = '{1, 3, 0};
  int n_chk = 0;
  int n_fail = 0;
  byte unsigned mb [3][128];

  always #5 clk = ~clk;

  data_ram #(.WAIT_STATES(1)) u_dut_ws1 (
    .i_clk(clk), .i_rst(rst[0]), .i_req(req[0]), .i_we(we), .i_addr(addr), .i_size(size),
    .i_unsigned(uns), .i_wdata(wdata), .o_ready(rdy[0]), .o_ack(ack[0]), .o_rdata(rdata[0]), .o_err(err[0]));
  data_ram #(.WAIT_STATES(3)) u_dut_ws3 (
    .i_clk(clk), .i_rst(rst[1]), .i_req(req[1]), .i_we(we), .i_addr(addr), .i_size(size),
    .i_unsigned(uns), .i_wdata(wdata), .o_ready(rdy[1]), .o_ack(ack[1]), .o_rdata(rdata[1]), .o_err(err[1]));
  data_ram #(.WAIT_STATES(0)) u_dut_ws0 (
    .i_clk(clk), .i_rst(rst[2]), .i_req(req[2]), .i_we(we), .i_addr(addr), .i_size(size),
    .i_unsigned(uns), .i_wdata(wdata), .o_ready(rdy[2]), .o_ack(ack[2]), .o_rdata(rdata[2]), .o_err(err[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h required %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Memory viewed as little-endian bytes; an access of n bytes must be n-aligned and in range.
  task automatic model(input int d, input bit w, input logic [31:0] a, input logic [1:0] sz,
                       input bit u, input logic [31:0] wd, output bit e, output logic [31:0] r);
    int n;
    n = 1 << sz;
    e = (sz == 2'b11) || (a % n != 0) || (a / 4 >= 32);
    r = '0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < n; i++) mb[d][a + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) r = r | (32'(mb[d][a + i]) << (8 * i));
        if (!u && n < 4 && r[8*n-1]) r = r | (32'hFFFF_FFFF << (8 * n));
      end
    end
  endtask

  task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [1:0] sz,
                     input bit u, input logic [31:0] wd, input string tag);
    bit          e;
    logic [31:0] r;
    int          n;
    n = 0;
    while (!rdy[d] && n < 50) begin @(negedge clk); n++; end
    we = w; addr = a; size = sz; uns = u; wdata = wd; req[d] = 1'b1;
    model(d, w, a, sz, u, wd, e, r);
    @(negedge clk);
    req[d] = 1'b0;
    addr = $urandom; wdata = $urandom; size = 2'($urandom); uns = 1'($urandom); we = 1'($urandom);
    n = 0;
    while (!ack[d] && n < 50) begin @(negedge clk); n++; end
    chk({tag, " latency"}, 32'(n), 32'(WS[d]));
    chk({tag, " rdata"}, rdata[d], r);
    chk({tag, " err"}, 32'(err[d]), 32'(e));
    @(negedge clk);
    chk({tag, " ack drop"}, 32'(ack[d]), 32'd0);
    chk({tag, " rdata idle"}, rdata[d], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: observed running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acks;
    int nsz;
    logic [31:0] ra;
    logic [1:0]  rs;
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 32; k++)
        for (int b = 0; b < 4; b++) mb[d][4*k + b] = 8'((k + 1) >> (8 * b));

    repeat (2) @(negedge clk);
    rst = 3'b000;
    for (int d = 0; d < 3; d++) begin
      chk("reset ready", 32'(rdy[d]), 32'd1);
      chk("reset ack", 32'(ack[d]), 32'd0);
      chk("reset err", 32'(err[d]), 32'd0);
      chk("reset rdata", rdata[d], 32'd0);
    end

    txn(0, 1'b0, 32'h8, 2'b10, 1'b0, 32'h0, "lw 0x8");
    chk("lw 0x8 value", {mb[0][11], mb[0][10], mb[0][9], mb[0][8]}, 32'h0000_0003);
    txn(0, 1'b1, 32'h5, 2'b00, 1'b0, 32'h0000_00AB, "sb 0x5");
    txn(0, 1'b0, 32'h4, 2'b10, 1'b0, 32'h0, "lw 0x4");
    txn(0, 1'b0, 32'h5, 2'b00, 1'b0, 32'h0, "lb 0x5");
    txn(0, 1'b0, 32'h5, 2'b00, 1'b1, 32'h0, "lbu 0x5");
    txn(0, 1'b0, 32'h3, 2'b01, 1'b0, 32'h0, "lh 0x3");
    txn(0, 1'b1, 32'h6, 2'b10, 1'b0, 32'h1234_5678, "sw 0x6");
    txn(0, 1'b0, 32'h4, 2'b10, 1'b0, 32'h0, "lw 0x4 after bad sw");
    txn(0, 1'b0, 32'h80, 2'b10, 1'b0, 32'h0, "lw 0x80");
    txn(0, 1'b0, 32'h0, 2'b11, 1'b0, 32'h0, "size 11");
    txn(0, 1'b1, 32'h7E, 2'b01, 1'b0, 32'hCAFE_8001, "sh 0x7E");
    txn(0, 1'b0, 32'h7E, 2'b01, 1'b0, 32'h0, "lh 0x7E");

    // Reset during WAIT aborts the store and suppresses the ack.
    we = 1'b1; addr = 32'h0; size = 2'b10; uns = 1'b0; wdata = 32'hDEAD_BEEF; req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    chk("abort no ack wait", 32'(ack[1]), 32'd0);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("abort ready", 32'(rdy[1]), 32'd1);
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack[1]) acks++;
    end
    chk("abort no ack after", 32'(acks), 32'd0);
    txn(1, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, "lw 0x0 after abort");

    // Reset wins over a simultaneous request.
    addr = 32'h8; size = 2'b10; we = 1'b0; req[0] = 1'b1; rst[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0; rst[0] = 1'b0;
    chk("rst vs req ready", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    chk("rst vs req ack", 32'(ack[0]), 32'd0);

    // Held request on the zero-wait instance: an accept every second cycle.
    we = 1'b0; addr = 32'h0; size = 2'b10; uns = 1'b0; req[2] = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack[2]) acks++;
      chk("b2b ack pattern", 32'(ack[2]), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk("b2b rdata", rdata[2], 32'h0000_0001);
    end
    req[2] = 1'b0;
    chk("b2b accepts", 32'(acks), 32'd3);
    @(negedge clk);

    for (int it = 0; it < 60; it++) begin
      rs = 2'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 159));
      nsz = 1 << rs;
      if ($urandom_range(0, 3) != 0) ra = ra & ~32'(nsz - 1);
      txn($urandom_range(0, 2), 1'($urandom), ra, rs, 1'($urandom), $urandom, "random");
    end

    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 32; k += 5) txn(d, 1'b0, 32'(4 * k), 2'b10, 1'b0, 32'h0, "sweep lw");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width in bits; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 32, number of 32-bit words.
REQ-004 SHALL have parameter WAIT_STATES, default 1, legal range 0..15, extra access-latency cycles.
REQ-005 SHALL have port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port i_req, input, 1, request valid.
REQ-008 SHALL have port i_we, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port i_addr, input, ADDR_WIDTH, byte address, little-endian.
REQ-010 SHALL have port i_size, input, 2, access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-011 SHALL have port i_unsigned, input, 1, load extension: 1 = zero-extend, 0 = sign-extend.
REQ-012 SHALL have port i_wdata, input, DATA_WIDTH, store data, right-justified.
REQ-013 SHALL have port o_ready, output, 1, high when a request can be accepted.
REQ-014 SHALL have port o_ack, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port o_rdata, output, DATA_WIDTH, load result, valid only while o_ack=1.
REQ-016 SHALL have port o_err, output, 1, error flag, valid only while o_ack=1.

Function
REQ-017 SHALL implement FSM IDLE, WAIT and RESP; o_ready=1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge with state IDLE and i_req=1, capturing i_we, i_addr, i_size, i_unsigned and i_wdata.
REQ-019 SHALL transition on acceptance as follows.
- WAIT_STATES=0: IDLE->RESP.
- Otherwise: IDLE->WAIT, stay in WAIT exactly WAIT_STATES cycles, then WAIT->RESP.
REQ-020 SHALL hold RESP one cycle with o_ack=1, then return to IDLE; accept at edge N gives o_ack in cycle N+1+WAIT_STATES.
REQ-021 SHALL ignore i_req outside IDLE (not queued); held i_req gives one accept per WAIT_STATES+2 cycles.
REQ-022 SHALL commit stores, and register load data, on the edge entering RESP.
REQ-023 SHALL set word index = addr[ADDR_WIDTH-1:2] and byte lane = addr[1:0].
REQ-024 SHALL flag error when any of the following holds: size 11; half with addr[0]=1; word with addr[1:0]!=0; word index >= DEPTH.
REQ-025 SHALL, on error: perform no write, o_rdata=0, o_err=1 with o_ack.
REQ-026 SHALL write only the addressed bytes on store.
- Byte: wdata[7:0] -> lane.
- Half: wdata[15:0] -> lanes addr[1:0] and addr[1:0]+1.
- Word: all four lanes.
- Other bytes unchanged.
REQ-027 SHALL, on load, extract the addressed byte/half/word and sign- or zero-extend to 32 bits per the captured i_unsigned; word ignores i_unsigned.
REQ-028 SHALL drive o_rdata=0 when o_ack=0, and o_rdata=0 for stores.
REQ-029 SHALL drive o_ack=0 and o_err=0 outside RESP.
REQ-030 SHALL preload memory at time zero so that word k = k+1 for all k < DEPTH.
REQ-031 SHALL decode i_addr only for acceptance-time capture; later i_addr changes have no effect.

Reset
REQ-032 SHALL, with i_rst=1 at a rising edge, set state IDLE, o_ready=1, o_ack=0, o_err=0, o_rdata=0, and clear the wait counter.
REQ-033 SHALL abort any in-flight transaction on reset: no ack; a store whose commit edge coincides with or follows reset is not written.
REQ-034 SHALL leave memory contents unchanged on reset; i_rst has priority over i_req on the same edge.

Verification
REQ-035 SHALL pass lw: WAIT_STATES=1, after reset, load word 0x8 -> o_ack two cycles after the accept edge, o_rdata=0x00000003, o_err=0.
REQ-036 SHALL pass byte store and extension: sb 0xAB at 0x5, then:
- lw 0x4 -> 0x0000AB02.
- lb 0x5 -> 0xFFFFFFAB.
- lbu 0x5 -> 0x000000AB.
REQ-037 SHALL pass misalignment: lh 0x3 -> o_err=1, o_rdata=0; sw 0x6 of 0x12345678 -> o_err=1, word 1 unchanged.
REQ-038 SHALL pass range and size checks: DEPTH=32, lw 0x80 -> o_err=1; i_size=11 at 0x0 -> o_err=1.
REQ-039 SHALL pass reset abort: WAIT_STATES=3, sw 0x0 of 0xDEADBEEF, i_rst pulsed during WAIT -> no o_ack, o_ready=1 next cycle, lw 0x0 -> 0x00000001.
REQ-040 SHALL pass back-to-back: WAIT_STATES=0, i_req held high for 6 cycles -> exactly 3 accepts, o_ack in alternate cycles.
